// File: rtl/packet_buffer_fifo.sv
// packet_buffer_fifo
//   Packet-oriented FIFO. Words are written tentatively and only become
//   visible to the reader once committed; an uncommitted packet can be
//   discarded as a whole.
//
//   Optional feature macro: PACKET_BUFFER_FIFO_ERR_FLAGS_EN
//     defined   -> overflow/underflow are sticky error flags
//     undefined -> overflow/underflow are tied to 0
//
//   Ports
//     clk, reset   : rising-edge clock, synchronous active-high reset
//     data_in      : write word
//     wr_en        : write request (dropped while full)
//     wr_commit    : publish all uncommitted words (includes same-cycle write)
//     wr_discard   : drop all uncommitted words (wins over wr_commit)
//     rd_en        : read request (refused while no committed data)
//     data_out     : registered read word, held between reads
//     data_av      : one-cycle pulse, data_out valid
//     full, afull  : occupancy flags including uncommitted words
//     empty, count : committed-only view seen by the reader
//     overflow     : sticky, write dropped because full
//     underflow    : sticky, read requested while empty
module packet_buffer_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 14,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH-64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  wr_commit,
  input  logic                  wr_discard,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_av,
  output logic                  full,
  output logic                  afull,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_P  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_P  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] cm_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] used;
  logic [ADDR_WIDTH:0] wr_ptr_inc;
  logic                wr_accept;
  logic                rd_accept;

  // Writer-side occupancy counts uncommitted words; reader side does not.
  always_comb begin
    used  = wr_ptr - rd_ptr;
    full  = (used == DEPTH_P);
    afull = (used >= AFULL_P);
    empty = (cm_ptr == rd_ptr);
    count = cm_ptr - rd_ptr;
  end

  // A discard kills any same-cycle write so the packet restarts cleanly.
  always_comb begin
    wr_accept  = wr_en && !full && !wr_discard;
    rd_accept  = rd_en && !empty;
    wr_ptr_inc = wr_accept ? (wr_ptr + PTR_ONE) : wr_ptr;
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
    end else if (wr_discard) begin
      wr_ptr <= cm_ptr;
    end else begin
      wr_ptr <= wr_ptr_inc;
      if (wr_commit) begin
        cm_ptr <= wr_ptr_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      data_out <= '0;
      data_av  <= 1'b0;
    end else begin
      data_av <= rd_accept;
      if (rd_accept) begin
        data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef PACKET_BUFFER_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !wr_discard) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_packet_buffer_fifo.sv
// Testbench for packet_buffer_fifo (DATA_WIDTH=32, ADDR_WIDTH=2, AFULL_LEVEL=3).
// Reference model: two queues, committed words and pending words.
module tb_packet_buffer_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        wr_en, wr_commit, wr_discard, rd_en;
  logic [31:0] data_out;
  logic        data_av, full, afull, empty;
  logic [2:0]  count;
  logic        overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] qc[$];
  logic [31:0] qp[$];
  logic [31:0] exp_dout;
  logic        exp_av;
  logic        m_ovf, m_unf;

  packet_buffer_fifo #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (2),
    .AFULL_LEVEL(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .wr_commit (wr_commit),
    .wr_discard(wr_discard),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .data_av   (data_av),
    .full      (full),
    .afull     (afull),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {full, afull, empty, count} from queue occupancy.
  function automatic logic [5:0] mflags();
    int u;
    logic [5:0] f;
    u = qc.size() + qp.size();
    f[5] = (u == 4);
    f[4] = (u >= 3);
    f[3] = (qc.size() == 0);
    f[2:0] = 3'(qc.size());
    return f;
  endfunction

  function automatic logic [1:0] merr();
`ifdef PACKET_BUFFER_FIFO_ERR_FLAGS_EN
    return {m_ovf, m_unf};
`else
    return 2'b00;
`endif
  endfunction

  // One clock with the given inputs; model advances from pre-edge state.
  task automatic step(input logic w, input logic [31:0] d, input logic c,
                      input logic x, input logic r);
    bit was_full, was_empty;
    wr_en = w; data_in = d; wr_commit = c; wr_discard = x; rd_en = r;
    was_full  = (qc.size() + qp.size()) == 4;
    was_empty = (qc.size() == 0);
    exp_av = 1'b0;
    if (r && !was_empty) begin
      exp_dout = qc.pop_front();
      exp_av   = 1'b1;
    end
    if (r && was_empty) m_unf = 1'b1;
    if (x) begin
      qp.delete();
    end else begin
      if (w && !was_full) qp.push_back(d);
      if (w && was_full)  m_ovf = 1'b1;
      if (c) while (qp.size() > 0) qc.push_back(qp.pop_front());
    end
    @(posedge clk); #1;
    wr_en = 0; wr_commit = 0; wr_discard = 0; rd_en = 0;
  endtask

  // Reset with arbitrary concurrent requests, which must all be ignored.
  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b1; data_in = $urandom; wr_commit = 1'b1; wr_discard = 1'b0; rd_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wr_en = 0; wr_commit = 0; wr_discard = 0; rd_en = 0;
    qc.delete(); qp.delete();
    exp_dout = '0; exp_av = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({full, afull, empty, count} !== 6'b001000) begin
      bad++; $display("FAIL reset_flags: got %b want %b", {full, afull, empty, count}, 6'b001000);
    end
    total++;
    if ({data_av, data_out, overflow, underflow} !== 35'd0) begin
      bad++; $display("FAIL reset_outputs: got av=%b dout=%h ovf=%b unf=%b want all 0",
                      data_av, data_out, overflow, underflow);
    end
  endtask

  task automatic test_commit_read();
    do_reset();
    step(1, 32'hA0, 0, 0, 0);
    step(1, 32'hA1, 0, 0, 0);
    step(1, 32'hA2, 1, 0, 0);
    total++;
    if ({full, afull, empty, count} !== 6'b010011) begin
      bad++; $display("FAIL commit_flags: got %b want %b", {full, afull, empty, count}, 6'b010011);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      total++;
      if ({data_av, data_out} !== {1'b1, 32'hA0 + 32'(i)}) begin
        bad++; $display("FAIL commit_read%0d: got av=%b dout=%h want av=1 dout=%h",
                        i, data_av, data_out, 32'hA0 + 32'(i));
      end
    end
    step(0, 0, 0, 0, 0);
    total++;
    if ({data_av, empty, count} !== 5'b01000) begin
      bad++; $display("FAIL commit_drained: got av=%b empty=%b count=%0d want 0 1 0",
                      data_av, empty, count);
    end
  endtask

  task automatic test_uncommitted();
    do_reset();
    step(1, 32'hB0, 0, 0, 0);
    step(1, 32'hB1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    total++;
    if ({data_av, afull, empty, count} !== 6'b001000) begin
      bad++; $display("FAIL uncommitted_hidden: got av=%b afull=%b empty=%b count=%0d want 0 0 1 0",
                      data_av, afull, empty, count);
    end
    total++;
    if ({overflow, underflow} !== merr()) begin
      bad++; $display("FAIL uncommitted_err: got %b want %b", {overflow, underflow}, merr());
    end
    step(0, 0, 1, 0, 0);
    total++;
    if (count !== 3'd2) begin
      bad++; $display("FAIL uncommitted_commit: got count=%0d want 2", count);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    total++;
    if ({data_av, data_out} !== {1'b1, 32'hB1}) begin
      bad++; $display("FAIL uncommitted_read: got av=%b dout=%h want 1 b1", data_av, data_out);
    end
  endtask

  task automatic test_discard();
    do_reset();
    step(1, 32'hC0, 1, 0, 0);
    step(1, 32'hC1, 0, 0, 0);
    step(1, 32'hC2, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    total++;
    if ({data_av, data_out} !== {1'b1, 32'hC0}) begin
      bad++; $display("FAIL discard_read0: got av=%b dout=%h want 1 c0", data_av, data_out);
    end
    step(0, 0, 0, 0, 1);
    total++;
    if ({data_av, data_out, count, empty} !== {1'b0, 32'hC0, 3'd0, 1'b1}) begin
      bad++; $display("FAIL discard_read1: got av=%b dout=%h count=%0d empty=%b want 0 c0 0 1",
                      data_av, data_out, count, empty);
    end
    // discard wins over commit and kills the same-cycle write
    step(1, 32'hC3, 0, 0, 0);
    step(1, 32'hE0, 1, 1, 0);
    total++;
    if ({full, afull, empty, count} !== 6'b001000) begin
      bad++; $display("FAIL discard_priority: got %b want %b", {full, afull, empty, count}, 6'b001000);
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    step(1, 32'hD0, 0, 0, 0);
    step(1, 32'hD1, 0, 0, 0);
    step(1, 32'hD2, 0, 0, 0);
    step(1, 32'hD3, 1, 0, 0);
    total++;
    if ({full, afull, empty, count} !== 6'b110100) begin
      bad++; $display("FAIL full_flags: got %b want %b", {full, afull, empty, count}, 6'b110100);
    end
    step(1, 32'hDD, 1, 0, 1);
    total++;
    if ({data_av, data_out} !== {1'b1, 32'hD0}) begin
      bad++; $display("FAIL full_read_oldest: got av=%b dout=%h want 1 d0", data_av, data_out);
    end
    total++;
    if ({full, afull, empty, count} !== 6'b010011) begin
      bad++; $display("FAIL full_write_dropped: got %b want %b", {full, afull, empty, count}, 6'b010011);
    end
    total++;
`ifdef PACKET_BUFFER_FIFO_ERR_FLAGS_EN
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_flag: got %b want 1", overflow);
    end
`else
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL overflow_flag: got %b want 0", overflow);
    end
`endif
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      total++;
      if ({data_av, data_out} !== {1'b1, 32'hD0 + 32'(i)}) begin
        bad++; $display("FAIL full_drain%0d: got av=%b dout=%h want 1 %h",
                        i, data_av, data_out, 32'hD0 + 32'(i));
      end
    end
    total++;
    if ({empty, count} !== 4'b1000) begin
      bad++; $display("FAIL full_drained: got empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) step(1, $urandom, (k == n - 1), 0, 0);
      total++;
      if (count > 3'd4 || count !== 3'(n)) begin
        bad++; $display("FAIL wrap_count%0d: got %0d want %0d", it, count, n);
      end
      for (int k = 0; k < n; k++) begin
        step(0, 0, 0, 0, 1);
        total++;
        if ({data_av, data_out} !== {exp_av, exp_dout}) begin
          bad++; $display("FAIL wrap_data%0d_%0d: got av=%b dout=%h want av=%b dout=%h",
                          it, k, data_av, data_out, exp_av, exp_dout);
        end
      end
    end
    // reset in the middle of a packet
    step(1, 32'h11, 0, 0, 0);
    step(1, 32'h22, 1, 0, 0);
    step(1, 32'h33, 0, 0, 0);
    do_reset();
    total++;
    if ({data_av, empty, count, full} !== 6'b010000) begin
      bad++; $display("FAIL midreset: got av=%b empty=%b count=%0d full=%b want 0 1 0 0",
                      data_av, empty, count, full);
    end
    step(1, 32'h44, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    total++;
    if ({data_av, data_out} !== {1'b1, 32'h44}) begin
      bad++; $display("FAIL midreset_fresh: got av=%b dout=%h want 1 44", data_av, data_out);
    end
  endtask

  task automatic test_random();
    logic w, c, x, r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 99) < 25);
      x = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 99) < 45);
      step(w, $urandom, c, x, r);
      total++;
      if ({data_av, data_out, full, afull, empty, count, overflow, underflow} !==
          {exp_av, exp_dout, mflags(), merr()}) begin
        bad++; $display("FAIL random%0d: got av=%b dout=%h flags=%b err=%b want av=%b dout=%h flags=%b err=%b",
                        i, data_av, data_out, {full, afull, empty, count}, {overflow, underflow},
                        exp_av, exp_dout, mflags(), merr());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    data_in = '0; wr_en = 0; wr_commit = 0; wr_discard = 0; rd_en = 0;
    exp_dout = '0; exp_av = 0; m_ovf = 0; m_unf = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_commit_read();
    test_uncommitted();
    test_discard();
    test_full_overflow();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
